prog_loader: RTL

//  Boot-time program loader placed upstream of the pipeline's byte-wide memory (m1).

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/prog_loader_ser.sv | 35 +++
 rtl/prog_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: loader state encoding and target-memory geometry defaults (shared with m1).
package pipeline_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_MEM_BYTES = 4096;
    localparam int DEF_CNT_W     = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/prog_loader_ser.sv
// 32->8 serializer: latches a word, presents bytes little-endian one per advance, flags byte 3.
module prog_loader_ser (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        advance,
    output logic [7:0]  data_byte,
    output logic        last
);

    logic [31:0] sh_r;
    logic [1:0]  ctr_r;

    // Word shift register and byte counter; the low byte is always the one on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r  <= 32'd0;
            ctr_r <= 2'd0;
        end else if (load) begin
            sh_r  <= word;
            ctr_r <= 2'd0;
        end else if (advance) begin
            sh_r  <= {8'd0, sh_r[31:8]};
            ctr_r <= ctr_r + 2'd1;
        end else begin
            sh_r  <= sh_r;
            ctr_r <= ctr_r;
        end
    end

    assign data_byte = sh_r[7:0];
    assign last      = (ctr_r == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams 32-bit words into byte-wide memory and holds the pipeline in reset until done.
// Optional running word checksum port enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import pipeline_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef PROG_LOADER_CHECKSUM_EN
    ,output logic [31:0]      checksum
`endif
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / 4);

    ldr_state_e        state_r, state_n;
    logic [CNT_W-1:0]  words_left_r;
    logic [ADDR_W-1:0] addr_r;
    logic              in_ready_r, mem_we_r, cpu_reset_r, busy_r, done_r, err_r;
    logic              start_s, too_big_s, accept_s, last_s, in_wr_s;

    assign start_s   = start && ((state_r == IDLE) || (state_r == DONE));
    assign too_big_s = (load_count > MAX_WORDS);
    assign accept_s  = in_valid && (state_r == WAIT);
    assign in_wr_s   = (state_r == WR);

    prog_loader_ser u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (accept_s),
        .word      (in_data),
        .advance   (in_wr_s),
        .data_byte (mem_wdata),
        .last      (last_s)
    );

    // Next-state logic; a zero or oversize count finishes immediately without writes.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    if ((load_count == {CNT_W{1'b0}}) || too_big_s) state_n = DONE;
                    else                                           state_n = WAIT;
                end else begin
                    state_n = state_r;
                end
            end
            WAIT: begin
                if (accept_s) state_n = WR;
                else          state_n = WAIT;
            end
            WR: begin
                if (last_s) begin
                    if (words_left_r == CNT_W'(1)) state_n = DONE;
                    else                           state_n = WAIT;
                end else begin
                    state_n = WR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and outputs; outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            words_left_r <= {CNT_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            in_ready_r   <= 1'b0;
            mem_we_r     <= 1'b0;
            cpu_reset_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == WAIT);
            mem_we_r    <= (state_n == WR);
            cpu_reset_r <= (state_n != DONE);
            busy_r      <= (state_n == WAIT) || (state_n == WR);
            done_r      <= (state_n == DONE);
            if (start_s) begin
                words_left_r <= load_count;
                err_r        <= too_big_s;
            end else if (in_wr_s && last_s) begin
                words_left_r <= words_left_r - CNT_W'(1);
                err_r        <= err_r;
            end else begin
                words_left_r <= words_left_r;
                err_r        <= err_r;
            end
            // Address saturates at the top of memory rather than wrapping onto byte 0.
            if (start_s) begin
                addr_r <= {ADDR_W{1'b0}};
            end else if (in_wr_s && (addr_r != {ADDR_W{1'b1}})) begin
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                addr_r <= addr_r;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0] cksum_r;

    // Modulo-2^32 sum of accepted words, cleared by each accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cksum_r <= 32'd0;
        end else if (start_s) begin
            cksum_r <= 32'd0;
        end else if (accept_s) begin
            cksum_r <= cksum_r + in_data;
        end else begin
            cksum_r <= cksum_r;
        end
    end

    assign checksum = cksum_r;
`endif

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign cpu_reset = cpu_reset_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
